// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage feeding decode.
// Holds the PC, issues in-order word requests to instruction memory, tracks
// in-flight request PCs, buffers returned {pc, inst} pairs in a small queue
// and hands them to decode over a val/rdy handshake. Redirects squash the
// queue and drop responses for requests still in flight.
// Optional build macro: FETCH_BYPASS_EN -- lets a response go straight to
// decode in the cycle it arrives when the queue is empty.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          QDEPTH   = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imemreq_val,
   input  logic        imemreq_rdy,
   output logic [31:0] imemreq_addr,
   input  logic        imemresp_val,
   input  logic [31:0] imemresp_data,
   input  logic        redirect_val,
   input  logic [31:0] redirect_target,
   output logic        inst_val,
   input  logic        inst_rdy,
   output logic [31:0] inst,
   output logic [31:0] inst_pc
);

   // Pointer width indexes QDEPTH slots; count width holds 0..QDEPTH.
   localparam int          PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int          CW     = $clog2(QDEPTH + 1);
   localparam logic [CW:0] QD_LIM = (CW + 1)'(QDEPTH);

   // Circular pointer advance that also works for non-power-of-two depths.
   function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
      if (p == PW'(QDEPTH - 1)) begin
         return '0;
      end
      return p + 1'b1;
   endfunction

   // Architectural PC of the next request.
   logic [31:0]   r_pc;

   // In-flight FIFO: PCs of requests accepted by memory but not yet answered.
   logic [31:0]   r_if_pc [QDEPTH];
   logic [PW-1:0] r_if_rd;
   logic [PW-1:0] r_if_wr;
   logic [CW-1:0] r_if_cnt;

   // Instruction queue of {pc, inst} awaiting decode.
   logic [31:0]   r_q_pc   [QDEPTH];
   logic [31:0]   r_q_inst [QDEPTH];
   logic [PW-1:0] r_q_rd;
   logic [PW-1:0] r_q_wr;
   logic [CW-1:0] r_q_cnt;

   // Number of upcoming responses that belong to a squashed path.
   logic [CW-1:0] r_drop;

   logic          w_credit;
   logic          w_req_fire;
   logic          w_resp_pop;
   logic          w_resp_keep;
   logic [31:0]   w_resp_pc;
   logic          w_q_empty;
   logic          w_bypass;
   logic          w_byp_take;
   logic          w_q_push;
   logic          w_q_pop;

   // Credit counts only registered occupancy: a pop this cycle does not
   // free a slot until the next cycle, keeping the request path short.
   assign w_credit    = ({1'b0, r_if_cnt} + {1'b0, r_q_cnt}) < QD_LIM;
   assign w_req_fire  = imemreq_val && imemreq_rdy;

   // Every response retires the oldest in-flight PC; it is kept only when
   // it belongs to the current path and no redirect happens this cycle.
   assign w_resp_pop  = imemresp_val && (r_if_cnt != '0);
   assign w_resp_pc   = r_if_pc[r_if_rd];
   assign w_resp_keep = w_resp_pop && !redirect_val && (r_drop == '0);
   assign w_q_empty   = (r_q_cnt == '0);

`ifdef FETCH_BYPASS_EN
   // Empty queue: present the arriving response to decode immediately and
   // skip the queue entirely if decode takes it.
   assign w_bypass    = w_resp_keep && w_q_empty;
   assign w_byp_take  = w_bypass && inst_rdy;
`else
   assign w_bypass    = 1'b0;
   assign w_byp_take  = 1'b0;
`endif

   assign w_q_push    = w_resp_keep && !w_byp_take;
   assign w_q_pop     = !w_q_empty && inst_rdy;

   assign imemreq_val  = rst_n && w_credit && !redirect_val;
   assign imemreq_addr = r_pc;

   assign inst_val = rst_n && (!w_q_empty || w_bypass);
   assign inst     = w_bypass ? imemresp_data : r_q_inst[r_q_rd];
   assign inst_pc  = w_bypass ? w_resp_pc     : r_q_pc[r_q_rd];

   // PC: redirect wins over sequential advance; low two bits forced to zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_pc <= RESET_PC;
      end else if (redirect_val) begin
         r_pc <= {redirect_target[31:2], 2'b00};
      end else if (w_req_fire) begin
         r_pc <= r_pc + 32'd4;
      end
   end

   // In-flight FIFO pointers and occupancy; survives redirects and drains
   // through the drop counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_if_rd  <= '0;
         r_if_wr  <= '0;
         r_if_cnt <= '0;
      end else begin
         if (w_req_fire) begin
            r_if_wr <= f_inc(r_if_wr);
         end
         if (w_resp_pop) begin
            r_if_rd <= f_inc(r_if_rd);
         end
         case ({w_req_fire, w_resp_pop})
            2'b10:   r_if_cnt <= r_if_cnt + 1'b1;
            2'b01:   r_if_cnt <= r_if_cnt - 1'b1;
            default: r_if_cnt <= r_if_cnt;
         endcase
      end
   end

   // In-flight FIFO storage: remember the PC of each accepted request.
   always_ff @(posedge clk) begin
      if (w_req_fire) begin
         r_if_pc[r_if_wr] <= r_pc;
      end
   end

   // Instruction queue pointers and occupancy; a redirect empties it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q_rd  <= '0;
         r_q_wr  <= '0;
         r_q_cnt <= '0;
      end else if (redirect_val) begin
         r_q_rd  <= '0;
         r_q_wr  <= '0;
         r_q_cnt <= '0;
      end else begin
         if (w_q_push) begin
            r_q_wr <= f_inc(r_q_wr);
         end
         if (w_q_pop) begin
            r_q_rd <= f_inc(r_q_rd);
         end
         case ({w_q_push, w_q_pop})
            2'b10:   r_q_cnt <= r_q_cnt + 1'b1;
            2'b01:   r_q_cnt <= r_q_cnt - 1'b1;
            default: r_q_cnt <= r_q_cnt;
         endcase
      end
   end

   // Instruction queue storage: capture the response with its request PC.
   always_ff @(posedge clk) begin
      if (w_q_push) begin
         r_q_pc[r_q_wr]   <= w_resp_pc;
         r_q_inst[r_q_wr] <= imemresp_data;
      end
   end

   // Drop counter: on redirect, every request still unanswered after this
   // cycle is wrong-path; a response landing in the redirect cycle is
   // discarded directly and therefore not counted.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_drop <= '0;
      end else if (redirect_val) begin
         r_drop <= r_if_cnt - CW'(w_resp_pop);
      end else if (w_resp_pop && (r_drop != '0)) begin
         r_drop <= r_drop - 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with an in-order memory model of
// programmable per-request latency and a golden in-order PC stream check.
`timescale 1ns/1ps
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imemreq_val;
   logic        imemreq_rdy;
   logic [31:0] imemreq_addr;
   logic        imemresp_val;
   logic [31:0] imemresp_data;
   logic        redirect_val;
   logic [31:0] redirect_target;
   logic        inst_val;
   logic        inst_rdy;
   logic [31:0] inst;
   logic [31:0] inst_pc;

   fetch_unit #(
      .RESET_PC (32'h0000_0100),
      .QDEPTH   (2)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imemreq_val     (imemreq_val),
      .imemreq_rdy     (imemreq_rdy),
      .imemreq_addr    (imemreq_addr),
      .imemresp_val    (imemresp_val),
      .imemresp_data   (imemresp_data),
      .redirect_val    (redirect_val),
      .redirect_target (redirect_target),
      .inst_val        (inst_val),
      .inst_rdy        (inst_rdy),
      .inst            (inst),
      .inst_pc         (inst_pc)
   );

   always #5 clk = ~clk;

   int          n_chk  = 0;
   int          n_pass = 0;
   int          n_fail = 0;
   int          cyc    = 0;
   int          lat    = 1;
   int          last_due = 0;
   int          n_req  = 0;
   int          n_cons = 0;
   logic [31:0] pend_addr [$];
   int          pend_due  [$];
   logic [31:0] got [$];
   logic [31:0] exp_pc;
   logic [31:0] resp_addr;
   logic        s_req_val;
   logic [31:0] s_req_addr;
   logic        s_inst_val;
   logic [31:0] s_inst;
   logic [31:0] s_inst_pc;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_A5A5;
   endfunction

   function automatic logic [31:0] got_at(input int i);
      if (i < got.size()) return got[i];
      return 32'hDEAD_DEAD;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One clock cycle: drive memory response, sample at negedge, update the
   // memory model and golden stream, then step to just after posedge.
   task automatic cycle();
      int          due;
      logic [31:0] a;
      imemresp_val  = 1'b0;
      imemresp_data = '0;
      resp_addr     = '0;
      if (rst_n && pend_addr.size() > 0 && pend_due[0] <= cyc) begin
         a = pend_addr.pop_front();
         void'(pend_due.pop_front());
         resp_addr     = a;
         imemresp_val  = 1'b1;
         imemresp_data = mem_word(a);
      end
      @(negedge clk);
      s_req_val  = imemreq_val;
      s_req_addr = imemreq_addr;
      s_inst_val = inst_val;
      s_inst     = inst;
      s_inst_pc  = inst_pc;
      if (rst_n && s_req_val && imemreq_rdy) begin
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         pend_addr.push_back(s_req_addr);
         pend_due.push_back(due);
         n_req++;
      end
      if (rst_n && s_inst_val && inst_rdy && !redirect_val) begin
         chk("stream_pc", s_inst_pc, exp_pc);
         chk("stream_inst", s_inst, mem_word(s_inst_pc));
         got.push_back(s_inst_pc);
         n_cons++;
         exp_pc = exp_pc + 32'd4;
      end
      if (rst_n && redirect_val) exp_pc = {redirect_target[31:2], 2'b00};
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_val = 1'b0;
      redirect_target = '0;
      inst_rdy = 1'b1;
      imemreq_rdy = 1'b1;
      lat = 1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("rst_req_val", {31'b0, s_req_val}, 32'd0);
         chk("rst_inst_val", {31'b0, s_inst_val}, 32'd0);
      end
      pend_addr.delete();
      pend_due.delete();
      rst_n = 1'b1;
      exp_pc = 32'h0000_0100;
      got.delete();
      last_due = cyc;
      n_req = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      imemreq_rdy = 1'b1;
      imemresp_val = 1'b0;
      imemresp_data = '0;
      redirect_val = 1'b0;
      redirect_target = '0;
      inst_rdy = 1'b1;
      @(posedge clk);
      #1;

      // Basic in-order fetch after reset, latency 1.
      do_reset();
      cycle();
      chk("first_req_val", {31'b0, s_req_val}, 32'd1);
      chk("first_req_addr", s_req_addr, 32'h0000_0100);
      repeat (7) cycle();
      chk("basic_pc0", got_at(0), 32'h0000_0100);
      chk("basic_pc1", got_at(1), 32'h0000_0104);
      chk("basic_pc2", got_at(2), 32'h0000_0108);

      // Backpressure: decode stalls 10 cycles, head holds steady.
      do_reset();
      inst_rdy = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         if (i >= 2) begin
            chk("bp_inst_val", {31'b0, s_inst_val}, 32'd1);
            chk("bp_inst_pc", s_inst_pc, 32'h0000_0100);
            chk("bp_inst", s_inst, mem_word(32'h0000_0100));
         end
      end
      chk("bp_req_count", n_req, 32'd2);
      inst_rdy = 1'b1;
      repeat (6) cycle();
      chk("bp_pc0", got_at(0), 32'h0000_0100);
      chk("bp_pc1", got_at(1), 32'h0000_0104);
      chk("bp_pc2", got_at(2), 32'h0000_0108);

      // Redirect with 0x108 and 0x10C in flight (latency 4).
      do_reset();
      lat = 4;
      repeat (8) cycle();
      chk("rd1_pre_count", got.size(), 32'd2);
      chk("rd1_pre_pc1", got_at(1), 32'h0000_0104);
      redirect_val = 1'b1;
      redirect_target = 32'h0000_0203;
      cycle();
      chk("rd1_req_val", {31'b0, s_req_val}, 32'd0);
      redirect_val = 1'b0;
      got.delete();
      repeat (12) cycle();
      chk("rd1_pc0", got_at(0), 32'h0000_0200);
      chk("rd1_pc1", got_at(1), 32'h0000_0204);

      // Redirect in the same cycle as the response for 0x104.
      do_reset();
      cycle();
      lat = 2;
      cycle();
      cycle();
      redirect_val = 1'b1;
      redirect_target = 32'h0000_0300;
      cycle();
      chk("rd2_resp_addr", resp_addr, 32'h0000_0104);
      chk("rd2_req_val", {31'b0, s_req_val}, 32'd0);
      chk("rd2_pre_count", got.size(), 32'd1);
      redirect_val = 1'b0;
      got.delete();
      lat = 1;
      cycle();
      chk("rd2_next_val", {31'b0, s_req_val}, 32'd1);
      chk("rd2_next_addr", s_req_addr, 32'h0000_0300);
      repeat (6) cycle();
      chk("rd2_pc0", got_at(0), 32'h0000_0300);
      chk("rd2_pc1", got_at(1), 32'h0000_0304);

      // PC wrap-around through a misaligned redirect to the top word.
      do_reset();
      redirect_val = 1'b1;
      redirect_target = 32'hFFFF_FFFE;
      cycle();
      chk("wrap_redir_val", {31'b0, s_req_val}, 32'd0);
      redirect_val = 1'b0;
      got.delete();
      cycle();
      chk("wrap_req_addr", s_req_addr, 32'hFFFF_FFFC);
      repeat (5) cycle();
      chk("wrap_pc0", got_at(0), 32'hFFFF_FFFC);
      chk("wrap_pc1", got_at(1), 32'h0000_0000);

      // Random latency, stalls and redirects against the golden stream.
      do_reset();
      n_cons = 0;
      for (int i = 0; i < 400; i++) begin
         inst_rdy = 1'($urandom_range(0, 1));
         imemreq_rdy = ($urandom_range(0, 3) != 0);
         lat = $urandom_range(1, 4);
         redirect_val = ($urandom_range(0, 9) == 0);
         redirect_target = $urandom;
         cycle();
      end
      redirect_val = 1'b0;
      imemreq_rdy = 1'b1;
      inst_rdy = 1'b1;
      chk("rand_progress", {31'b0, (n_cons > 20)}, 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
